// File: rtl/vc_pop_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vc_pop_scheduler_pkg
//  Brief    : Shared state encoding and default widths for vc_pop_scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
package vc_pop_scheduler_pkg;

    localparam int DEF_CNT_W    = 5;
    localparam int DEF_WEIGHT_W = 4;
    localparam int DEF_STAT_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SERVE0 = 2'd1,
        ST_SERVE1 = 2'd2,
        ST_STALL  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/vc_pop_scheduler_pop_stat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : vc_pop_scheduler_pop_stat_counter
//  Brief    : Wrapping pop statistics counter (pop_stat_counter), reset-only clear.
//  Revision : 1.0 - initial release
// ============================================================================
module vc_pop_scheduler_pop_stat_counter
    import vc_pop_scheduler_pkg::*;
#(
    parameter int STAT_W = DEF_STAT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    output logic [STAT_W-1:0] count
);

    logic [STAT_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + STAT_W'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/vc_pop_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : vc_pop_scheduler
//  Brief    : Main-FIFO pop plus weighted round-robin VC0/VC1 pop scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
module vc_pop_scheduler
    import vc_pop_scheduler_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int WEIGHT_W = DEF_WEIGHT_W,
    parameter int STAT_W   = DEF_STAT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [CNT_W-1:0]    mf_count,
    input  logic [CNT_W-1:0]    vc0_count,
    input  logic [CNT_W-1:0]    vc1_count,
    input  logic                pause_vc0,
    input  logic                pause_vc1,
    input  logic                pause_d0,
    input  logic                pause_d1,
    input  logic [WEIGHT_W-1:0] weight_vc0,
    input  logic [WEIGHT_W-1:0] weight_vc1,
    output logic                pop_mf,
    output logic                pop_vc0,
    output logic                pop_vc1,
    output logic                grant_vc,
    output logic                stalled,
    output logic [STAT_W-1:0]   pops_vc0,
    output logic [STAT_W-1:0]   pops_vc1
);

    localparam logic [WEIGHT_W-1:0] c_CREDIT_ONE = WEIGHT_W'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WEIGHT_W-1:0] r_credit;
    logic [WEIGHT_W-1:0] w_credit_nxt;
    logic                r_pop_mf;
    logic                r_pop_vc0;
    logic                r_pop_vc1;
    logic                r_grant_vc;
    logic                r_stalled;
    logic                w_pop_mf_nxt;
    logic                w_pop0_nxt;
    logic                w_pop1_nxt;
    logic                w_grant_nxt;
    logic                w_stalled_nxt;

    logic                w_pause_d;
    logic                w_elig0;
    logic                w_elig1;
    logic [WEIGHT_W-1:0] w_w0;
    logic [WEIGHT_W-1:0] w_w1;
    logic                w_cur_vc;
    logic                w_elig_cur;
    logic                w_elig_oth;
    logic [WEIGHT_W-1:0] w_weight_cur;
    logic                w_turn_open;
    logic                w_do_pop;
    logic                w_pop_vc;

    // Compare against the in-flight pop so the last word is never popped twice.
    assign w_pause_d = pause_d0 | pause_d1;
    assign w_elig0   = enable & ~w_pause_d & (vc0_count > {{(CNT_W-1){1'b0}}, r_pop_vc0});
    assign w_elig1   = enable & ~w_pause_d & (vc1_count > {{(CNT_W-1){1'b0}}, r_pop_vc1});
    assign w_w0      = (weight_vc0 == '0) ? c_CREDIT_ONE : weight_vc0;
    assign w_w1      = (weight_vc1 == '0) ? c_CREDIT_ONE : weight_vc1;

    assign w_pop_mf_nxt = enable & ~pause_vc0 & ~pause_vc1 &
                          (mf_count > {{(CNT_W-1){1'b0}}, r_pop_mf});

    // Credit is zero in IDLE, so the "turn open" test doubles as IDLE's first pick.
    assign w_cur_vc     = (r_state == ST_IDLE) ? 1'b0 : r_grant_vc;
    assign w_elig_cur   = w_cur_vc ? w_elig1 : w_elig0;
    assign w_elig_oth   = w_cur_vc ? w_elig0 : w_elig1;
    assign w_weight_cur = w_cur_vc ? w_w1 : w_w0;
    assign w_turn_open  = (r_credit < w_weight_cur);

    always_comb begin
        w_state_nxt   = r_state;
        w_credit_nxt  = r_credit;
        w_grant_nxt   = r_grant_vc;
        w_pop0_nxt    = 1'b0;
        w_pop1_nxt    = 1'b0;
        w_stalled_nxt = 1'b0;
        w_do_pop      = 1'b0;
        w_pop_vc      = w_cur_vc;

        if (!enable) begin
            w_state_nxt  = ST_IDLE;
            w_credit_nxt = '0;
        end else if (w_pause_d && (r_state != ST_IDLE)) begin
            w_state_nxt   = ST_STALL;
            w_stalled_nxt = 1'b1;
        end else if (w_elig_cur && w_turn_open) begin
            w_do_pop     = 1'b1;
            w_credit_nxt = r_credit + c_CREDIT_ONE;
        end else if (w_elig_oth) begin
            w_do_pop     = 1'b1;
            w_pop_vc     = ~w_cur_vc;
            w_credit_nxt = c_CREDIT_ONE;
        end else if (w_elig_cur) begin
            w_do_pop     = 1'b1;
            w_credit_nxt = c_CREDIT_ONE;
        end else begin
            w_state_nxt  = ST_IDLE;
            w_credit_nxt = '0;
        end

        if (w_do_pop) begin
            w_state_nxt = w_pop_vc ? ST_SERVE1 : ST_SERVE0;
            w_grant_nxt = w_pop_vc;
            w_pop0_nxt  = ~w_pop_vc;
            w_pop1_nxt  = w_pop_vc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_credit   <= '0;
            r_pop_mf   <= 1'b0;
            r_pop_vc0  <= 1'b0;
            r_pop_vc1  <= 1'b0;
            r_grant_vc <= 1'b0;
            r_stalled  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_credit   <= w_credit_nxt;
            r_pop_mf   <= w_pop_mf_nxt;
            r_pop_vc0  <= w_pop0_nxt;
            r_pop_vc1  <= w_pop1_nxt;
            r_grant_vc <= w_grant_nxt;
            r_stalled  <= w_stalled_nxt;
        end
    end

    vc_pop_scheduler_pop_stat_counter #(.STAT_W(STAT_W)) u_stat_vc0 (
        .clk   (clk),
        .reset (reset),
        .inc   (r_pop_vc0),
        .count (pops_vc0)
    );

    vc_pop_scheduler_pop_stat_counter #(.STAT_W(STAT_W)) u_stat_vc1 (
        .clk   (clk),
        .reset (reset),
        .inc   (r_pop_vc1),
        .count (pops_vc1)
    );

    assign pop_mf   = r_pop_mf;
    assign pop_vc0  = r_pop_vc0;
    assign pop_vc1  = r_pop_vc1;
    assign grant_vc = r_grant_vc;
    assign stalled  = r_stalled;

endmodule
`default_nettype wire

// File: tb/tb_vc_pop_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vc_pop_scheduler
//  Brief    : Scoreboard bench for vc_pop_scheduler using hand-derived cycle tables.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vc_pop_scheduler;

    localparam int CNT_W    = 5;
    localparam int WEIGHT_W = 4;
    localparam int STAT_W   = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic                enable;
    logic [CNT_W-1:0]    mf_count;
    logic [CNT_W-1:0]    vc0_count;
    logic [CNT_W-1:0]    vc1_count;
    logic                pause_vc0;
    logic                pause_vc1;
    logic                pause_d0;
    logic                pause_d1;
    logic [WEIGHT_W-1:0] weight_vc0;
    logic [WEIGHT_W-1:0] weight_vc1;
    logic                pop_mf;
    logic                pop_vc0;
    logic                pop_vc1;
    logic                grant_vc;
    logic                stalled;
    logic [STAT_W-1:0]   pops_vc0;
    logic [STAT_W-1:0]   pops_vc1;

    int          total = 0;
    int          bad   = 0;
    logic [4:0]  exp_q[$];
    logic        track;
    logic        p0_prev;
    logic        p1_prev;
    logic        mf_prev;

    vc_pop_scheduler #(
        .CNT_W    (CNT_W),
        .WEIGHT_W (WEIGHT_W),
        .STAT_W   (STAT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .mf_count   (mf_count),
        .vc0_count  (vc0_count),
        .vc1_count  (vc1_count),
        .pause_vc0  (pause_vc0),
        .pause_vc1  (pause_vc1),
        .pause_d0   (pause_d0),
        .pause_d1   (pause_d1),
        .weight_vc0 (weight_vc0),
        .weight_vc1 (weight_vc1),
        .pop_mf     (pop_mf),
        .pop_vc0    (pop_vc0),
        .pop_vc1    (pop_vc1),
        .grant_vc   (grant_vc),
        .stalled    (stalled),
        .pops_vc0   (pops_vc0),
        .pops_vc1   (pops_vc1)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected vector is {pop_vc0, pop_vc1, grant_vc, stalled, pop_mf} after one edge.
    task automatic expect_cycle(input string tag, input logic [4:0] exp);
        logic [4:0] got;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        if (track) begin
            vc0_count = vc0_count - {{(CNT_W-1){1'b0}}, p0_prev};
            vc1_count = vc1_count - {{(CNT_W-1){1'b0}}, p1_prev};
            mf_count  = mf_count  - {{(CNT_W-1){1'b0}}, mf_prev};
        end
        @(negedge clk);
        got = {pop_vc0, pop_vc1, grant_vc, stalled, pop_mf};
        check_eq(tag, {27'd0, got}, {27'd0, exp_q.pop_front()});
        check_eq({tag, "_excl"}, {31'd0, pop_vc0 & pop_vc1}, 32'd0);
        p0_prev = pop_vc0;
        p1_prev = pop_vc1;
        mf_prev = pop_mf;
    endtask

    task automatic apply_reset();
        reset      = 1'b1;
        enable     = 1'b0;
        mf_count   = '0;
        vc0_count  = '0;
        vc1_count  = '0;
        pause_vc0  = 1'b0;
        pause_vc1  = 1'b0;
        pause_d0   = 1'b0;
        pause_d1   = 1'b0;
        weight_vc0 = 4'd1;
        weight_vc1 = 4'd1;
        track      = 1'b0;
        p0_prev    = 1'b0;
        p1_prev    = 1'b0;
        mf_prev    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_flags", {27'd0, pop_vc0, pop_vc1, grant_vc, stalled, pop_mf}, 32'd0);
        check_eq("rst_stats", {pops_vc0, pops_vc1}, 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        // Short drain of VC0 with weight 2: three pops then idle.
        apply_reset();
        enable = 1'b1; weight_vc0 = 4'd2; weight_vc1 = 4'd2;
        vc0_count = 5'd3; track = 1'b1;
        expect_cycle("t1_c1", 5'b10000);
        expect_cycle("t1_c2", 5'b10000);
        expect_cycle("t1_c3", 5'b10000);
        expect_cycle("t1_c4", 5'b00000);
        expect_cycle("t1_c5", 5'b00000);
        check_eq("t1_pops0", {16'd0, pops_vc0}, 32'd3);

        // Weights 3/1, both loaded: grant pattern 0,0,0,1 with no gaps.
        apply_reset();
        enable = 1'b1; weight_vc0 = 4'd3; weight_vc1 = 4'd1;
        vc0_count = 5'd8; vc1_count = 5'd8;
        for (int r = 0; r < 2; r++) begin
            expect_cycle("t2_v0a", 5'b10000);
            expect_cycle("t2_v0b", 5'b10000);
            expect_cycle("t2_v0c", 5'b10000);
            expect_cycle("t2_v1",  5'b01100);
        end
        check_eq("t2_pops0", {16'd0, pops_vc0}, 32'd6);
        check_eq("t2_pops1", {16'd0, pops_vc1}, 32'd1);

        // Zero weights act as 1: strict alternation.
        apply_reset();
        enable = 1'b1; weight_vc0 = 4'd0; weight_vc1 = 4'd0;
        vc0_count = 5'd8; vc1_count = 5'd8;
        for (int r = 0; r < 3; r++) begin
            expect_cycle("t3_v0", 5'b10000);
            expect_cycle("t3_v1", 5'b01100);
        end
        check_eq("t3_pops0", {16'd0, pops_vc0}, 32'd3);
        check_eq("t3_pops1", {16'd0, pops_vc1}, 32'd2);

        // Destination pause after VC1's first pop; VC1 resumes its turn.
        apply_reset();
        enable = 1'b1; weight_vc0 = 4'd1; weight_vc1 = 4'd3;
        vc0_count = 5'd8; vc1_count = 5'd8;
        expect_cycle("t4_v0",     5'b10000);
        expect_cycle("t4_v1",     5'b01100);
        pause_d1 = 1'b1;
        expect_cycle("t4_stall1", 5'b00110);
        expect_cycle("t4_stall2", 5'b00110);
        pause_d1 = 1'b0;
        expect_cycle("t4_res1",   5'b01100);
        expect_cycle("t4_res2",   5'b01100);
        expect_cycle("t4_back0",  5'b10000);
        check_eq("t4_pops0", {16'd0, pops_vc0}, 32'd1);
        check_eq("t4_pops1", {16'd0, pops_vc1}, 32'd3);

        // Main FIFO: single pulse for one word, blocked by VC pause.
        apply_reset();
        enable = 1'b1; mf_count = 5'd1; track = 1'b1;
        expect_cycle("t5_mf1",   5'b00001);
        expect_cycle("t5_mf2",   5'b00000);
        expect_cycle("t5_mf3",   5'b00000);
        track = 1'b0; mf_count = 5'd5; pause_vc0 = 1'b1;
        expect_cycle("t5_pv_a",  5'b00000);
        expect_cycle("t5_pv_b",  5'b00000);
        pause_vc0 = 1'b0;
        expect_cycle("t5_go_a",  5'b00001);
        expect_cycle("t5_go_b",  5'b00001);

        // Enable drop mid-turn, then asynchronous reset mid-cycle.
        apply_reset();
        enable = 1'b1; weight_vc0 = 4'd4; vc0_count = 5'd8;
        expect_cycle("t6_c1", 5'b10000);
        expect_cycle("t6_c2", 5'b10000);
        enable = 1'b0;
        expect_cycle("t6_off", 5'b00000);
        enable = 1'b1;
        expect_cycle("t6_on", 5'b10000);
        #2 reset = 1'b1;
        #1;
        check_eq("t6_async_pop", {31'd0, pop_vc0}, 32'd0);
        check_eq("t6_async_stat", {16'd0, pops_vc0}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
